// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract unit: one BLOCK-bit carry-lookahead group is resolved per stage,
// and the group carry-out is registered into the next stage.
`timescale 1ns/1ps

module pipelined_cla_adder #(
    parameter int N     = 16,
    parameter int BLOCK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int STAGES = N / BLOCK;

    if (N % BLOCK != 0) begin : g_bad_block
        $error("pipelined_cla_adder: N (%0d) must be a multiple of BLOCK (%0d)", N, BLOCK);
    end

    // Flat two-level carry expansion: c[i] = OR over sources j of (gen_j AND p[j..i-1]),
    // where source 0 is the group carry-in. No carry ripples through the group.
    function automatic logic [BLOCK:0] cla_carries(input logic [BLOCK-1:0] p,
                                                   input logic [BLOCK-1:0] g,
                                                   input logic             c0);
        logic [BLOCK:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 1; i <= BLOCK; i++) begin
            for (int j = 0; j <= i; j++) begin
                if (j == 0) begin
                    term = c0;
                end else begin
                    term = g[j-1];
                end
                for (int k = j; k < i; k++) begin
                    term = term & p[k];
                end
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    // Handshake: a beat moves in on in_valid & in_ready and out on out_valid & out_ready.
    // The whole pipe advances together (bubbles included) whenever the output slot is
    // empty or being drained, so in_ready never depends on in_valid.
    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Stage registers: operands travel whole; sum accumulates the resolved low groups.
    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_c;
    logic [N-1:0]      st_a   [STAGES];
    logic [N-1:0]      st_b   [STAGES];
    logic [N-1:0]      st_sum [STAGES];

    logic [N-1:0]      grp_sum  [STAGES];
    logic [STAGES-1:0] grp_cout;
    logic              ovf_next;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        logic [N-1:0]     sum_next;

        assign p = st_a[s][s*BLOCK +: BLOCK] ^ st_b[s][s*BLOCK +: BLOCK];
        assign g = st_a[s][s*BLOCK +: BLOCK] & st_b[s][s*BLOCK +: BLOCK];
        assign c = cla_carries(p, g, st_c[s]);

        always_comb begin
            sum_next                      = st_sum[s];
            sum_next[s*BLOCK +: BLOCK]    = p ^ c[BLOCK-1:0];
        end

        assign grp_sum[s]  = sum_next;
        assign grp_cout[s] = c[BLOCK];

        // Carry into bit N-1 lives inside the top group.
        if (s == STAGES - 1) begin : g_last
            assign ovf_next = c[BLOCK-1] ^ c[BLOCK];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_valid  <= '0;
            st_c      <= '0;
            for (int s = 0; s < STAGES; s++) begin
                st_a[s]   <= '0;
                st_b[s]   <= '0;
                st_sum[s] <= '0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (en) begin
            st_valid[0] <= in_valid;
            // Operands are captured only on accept; a bubble keeps the previous data.
            if (in_valid) begin
                st_a[0]   <= a;
                st_b[0]   <= sub ? ~b : b;
                st_c[0]   <= cin;
                st_sum[0] <= '0;
            end
            for (int s = 1; s < STAGES; s++) begin
                st_valid[s] <= st_valid[s-1];
                st_a[s]     <= st_a[s-1];
                st_b[s]     <= st_b[s-1];
                st_c[s]     <= grp_cout[s-1];
                st_sum[s]   <= grp_sum[s-1];
            end
            out_valid <= st_valid[STAGES-1];
            if (st_valid[STAGES-1]) begin
                sum  <= grp_sum[STAGES-1];
                cout <= grp_cout[STAGES-1];
                ovf  <= ovf_next;
            end
        end
    end

    a_hold_stalled : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(sum) && $stable(cout) && $stable(ovf)));

endmodule
